// File: rtl/instr_fetch_unit.sv
// Program counter and instruction-fetch stage of the multicycle core.
// Issues one word read per fetch request, waits out memory wait states,
// latches the instruction for decode and applies the selected PC update.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetch in flight; PC updates and fetch_start are accepted
// REQ   | mem_req asserted for one cycle with mem_addr = pc_cur
// WAIT  | waiting for mem_rvalid; response latched into instr
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_old,
  output logic            busy,
  input  logic            pc_update,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic            misaligned
);

  localparam logic [1:0]  PC_SRC__INCREMENT  = 2'd0;
  localparam logic [1:0]  PC_SRC__JUMP       = 2'd1;
  localparam logic [1:0]  PC_SRC__ALU_RESULT = 2'd2;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            start_fetch;
  logic            accept_rsp;
  logic            upd_en;
  logic            tgt_valid;
  logic [XLEN-1:0] tgt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    busy        = 1'b0;
    start_fetch = 1'b0;
    accept_rsp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_start) begin
          start_fetch = 1'b1;
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          accept_rsp = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr = pc_cur;

  // PC target selection; unknown encodings leave the PC untouched.
  always_comb begin
    tgt       = pc_cur;
    tgt_valid = 1'b0;
    case (pc_src)
      PC_SRC__INCREMENT: begin
        tgt       = pc_old + XLEN'(4);
        tgt_valid = 1'b1;
      end
      PC_SRC__JUMP: begin
        tgt       = pc_old + imm_ext;
        tgt_valid = 1'b1;
      end
      PC_SRC__ALU_RESULT: begin
        tgt       = alu_result & ~XLEN'(1);
        tgt_valid = 1'b1;
      end
      default: begin
        tgt       = pc_cur;
        tgt_valid = 1'b0;
      end
    endcase
  end

  assign upd_en = pc_update && (state == S_IDLE) && tgt_valid;

  // PC, instruction latch and misalignment pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_cur      <= RESET_PC;
      pc_old      <= RESET_PC;
      instr       <= INSTR_NOP;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (upd_en) begin
        if (tgt[1:0] != 2'b00) misaligned <= 1'b1;
        else                   pc_cur     <= tgt;
      end
      if (start_fetch) instr_valid <= 1'b0;
      if (accept_rsp) begin
        instr       <= mem_rdata;
        pc_old      <= pc_cur;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC-update vector table plus
// hand-written fetch, wait-state, same-cycle and reset-abort sequences.
module tb_instr_fetch_unit;

  localparam logic [1:0]  SRC_INC = 2'd0;
  localparam logic [1:0]  SRC_JMP = 2'd1;
  localparam logic [1:0]  SRC_ALU = 2'd2;
  localparam logic [1:0]  SRC_BAD = 2'd3;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_cur;
  logic [31:0] pc_old;
  logic        busy;
  logic        pc_update = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] imm_ext = '0;
  logic [31:0] alu_result = '0;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc_cur(pc_cur), .pc_old(pc_old), .busy(busy), .pc_update(pc_update),
    .pc_src(pc_src), .imm_ext(imm_ext), .alu_result(alu_result),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_upd(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    pc_update  = 1'b1;
    pc_src     = src;
    imm_ext    = imm;
    alu_result = alu;
    tick();
    pc_update  = 1'b0;
  endtask

  // Full fetch with 'waits' memory wait states; checks the request and the latch.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("req_pulse", 32'(mem_req), 32'd1);
    chk("req_addr", mem_addr, addr);
    chk("valid_cleared", 32'(instr_valid), 32'd0);
    tick();
    chk("req_drop", 32'(mem_req), 32'd0);
    for (int i = 0; i < waits; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    chk("instr", instr, data);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("pc_old", pc_old, addr);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, SRC_INC, 32'h0,         32'h0,   32'h0000_0104, 1'b0};
    vecs[1] = '{32'hFFFF_FFFC, SRC_INC, 32'h0,         32'h0,   32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0200, SRC_ALU, 32'h0,         32'h105, 32'h0000_0104, 1'b0};
    vecs[3] = '{32'h0000_0104, SRC_ALU, 32'h0,         32'h106, 32'h0000_0104, 1'b1};
    vecs[4] = '{32'h0000_0000, SRC_JMP, 32'h6,         32'h0,   32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, SRC_JMP, 32'h10,        32'h0,   32'h0000_0010, 1'b0};
    vecs[6] = '{32'h0000_0040, SRC_JMP, 32'hFFFF_FFF8, 32'h0,   32'h0000_0038, 1'b0};
    vecs[7] = '{32'h0000_0040, SRC_BAD, 32'h4,         32'h80,  32'h0000_0040, 1'b0};

    // Reset, with a stray fetch_start that reset must override.
    fetch_start = 1'b1;
    tick();
    tick();
    fetch_start = 1'b0;
    reset = 1'b0;
    chk("rst_pc_cur", pc_cur, 32'h0);
    chk("rst_pc_old", pc_old, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);

    // Fetch at 0, jump by 16, fetch at 16.
    do_fetch(32'h0, 32'h0100_00EF, 0);
    apply_upd(SRC_JMP, 32'd16, 32'h0);
    chk("jal_pc", pc_cur, 32'h10);
    do_fetch(32'h10, 32'h1234_5678, 1);

    // Three wait states: instr_valid rises exactly 6 cycles after fetch_start.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("ws_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("ws_valid_c%0d", c), 32'(instr_valid), 32'd0);
      if (c == 5) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0001;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    chk("ws_valid_c6", 32'(instr_valid), 32'd1);
    chk("ws_instr", instr, 32'hCAFE_0001);
    chk("ws_busy_c6", 32'(busy), 32'd0);

    // PC-update table.
    foreach (vecs[k]) begin
      apply_upd(SRC_ALU, 32'h0, vecs[k].start_pc);
      do_fetch(vecs[k].start_pc, 32'h0000_0013 + 32'(k), 0);
      apply_upd(vecs[k].src, vecs[k].imm, vecs[k].alu);
      chk($sformatf("vec%0d_pc", k), pc_cur, vecs[k].exp_pc);
      chk($sformatf("vec%0d_mis", k), 32'(misaligned), 32'(vecs[k].exp_mis));
      tick();
      chk($sformatf("vec%0d_mis_end", k), 32'(misaligned), 32'd0);
    end

    // Same-cycle pc_update and fetch_start: request uses the new PC.
    fetch_start = 1'b1;
    apply_upd(SRC_ALU, 32'h0, 32'h300);
    fetch_start = 1'b0;
    chk("same_req", 32'(mem_req), 32'd1);
    chk("same_addr", mem_addr, 32'h300);
    // rvalid during REQ must not be accepted.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("early_rvalid_valid", 32'(instr_valid), 32'd0);
    chk("early_rvalid_busy", 32'(busy), 32'd1);
    // fetch_start and pc_update while busy are ignored.
    fetch_start = 1'b1;
    apply_upd(SRC_ALU, 32'h0, 32'h500);
    fetch_start = 1'b0;
    chk("busy_upd_pc", pc_cur, 32'h300);
    chk("busy_fs_noreq", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0ABC;
    tick();
    mem_rvalid = 1'b0;
    chk("same_instr", instr, 32'h0000_0ABC);
    chk("same_pc_old", pc_old, 32'h300);
    tick();
    chk("no_queued_req", 32'(mem_req), 32'd0);
    chk("no_queued_busy", 32'(busy), 32'd0);

    // rvalid while idle is ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_0000;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_instr", instr, 32'h0000_0ABC);

    // Reset in WAIT, then a stale response.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    chk("abort_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("abort_instr", instr, NOP);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_pc_cur", pc_cur, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
